// File: rtl/add16u_err_monitor.sv
// Error-statistics monitor for a 16-bit unsigned approximate adder.
// Squared-error path built only when ADD16U_ERRMON_MSE_EN is defined.
module add16u_err_monitor #(
  parameter int CNT_W = 32,
  parameter int SAE_W = 48,
  parameter int SSE_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [16:0]      in_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [16:0]      wce,
  output logic [SAE_W-1:0] sae,
  output logic [SSE_W-1:0] sse
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_acc;
  logic             r_s1_vld;
  logic [16:0]      r_s1_err;
  logic [CNT_W-1:0] r_smp;
  logic [CNT_W-1:0] r_errc;
  logic [16:0]      r_wce;
  logic [SAE_W-1:0] r_sae;

  logic             w_accept;
  logic             w_last;
  logic [16:0]      w_exact;
  logic [16:0]      w_err;
  logic [SAE_W:0]   w_sae_sum;
  logic [CNT_W-1:0] w_smp_nxt;
  logic [CNT_W-1:0] w_errc_nxt;

  assign in_ready = (r_state == S_RUN) && (r_acc < r_n);
  assign w_accept = in_valid && in_ready;
  assign w_last   = w_accept && ((r_acc + CNT_W'(1)) == r_n);
  assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);

  assign w_exact = {1'b0, in_a} + {1'b0, in_b};
  assign w_err   = (w_exact >= in_o) ? (w_exact - in_o)
                                     : (in_o - w_exact);

  assign w_smp_nxt  = (&r_smp) ? r_smp : r_smp + CNT_W'(1);
  assign w_errc_nxt = ((&r_errc) || (r_s1_err == 17'd0)) ?
                      r_errc : r_errc + CNT_W'(1);
  assign w_sae_sum  = {1'b0, r_sae}
                    + {{(SAE_W+1-17){1'b0}}, r_s1_err};

  // Run control: start always wins and restarts from scratch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_acc   <= '0;
    end else if (start) begin
      r_n     <= n_samples;
      r_acc   <= '0;
      r_state <= (n_samples == '0) ? S_DONE : S_RUN;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_accept) begin
            r_acc <= r_acc + CNT_W'(1);
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_s1_vld) r_state <= S_DONE;
        end
        default: ;
      endcase
    end
  end

  // Stage 1: register the absolute error of each accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_err <= '0;
    end else if (start) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) r_s1_err <= w_err;
    end
  end

  // Stage 2: saturating statistics update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp  <= '0;
      r_errc <= '0;
      r_wce  <= '0;
      r_sae  <= '0;
    end else if (start) begin
      r_smp  <= '0;
      r_errc <= '0;
      r_wce  <= '0;
      r_sae  <= '0;
    end else if (r_s1_vld) begin
      r_smp  <= w_smp_nxt;
      r_errc <= w_errc_nxt;
      if (r_s1_err > r_wce) r_wce <= r_s1_err;
      r_sae  <= w_sae_sum[SAE_W] ? '1 : w_sae_sum[SAE_W-1:0];
    end
  end

  assign smp_cnt = r_smp;
  assign err_cnt = r_errc;
  assign wce     = r_wce;
  assign sae     = r_sae;

`ifdef ADD16U_ERRMON_MSE_EN
  logic [SSE_W-1:0] r_sse;
  logic [33:0]      w_sq;
  logic [SSE_W:0]   w_sse_sum;

  assign w_sq      = {17'd0, r_s1_err} * {17'd0, r_s1_err};
  assign w_sse_sum = {1'b0, r_sse}
                   + {{(SSE_W+1-34){1'b0}}, w_sq};

  // Saturating sum of squared errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sse <= '0;
    end else if (start) begin
      r_sse <= '0;
    end else if (r_s1_vld) begin
      r_sse <= w_sse_sum[SSE_W] ? '1 : w_sse_sum[SSE_W-1:0];
    end
  end

  assign sse = r_sse;
`else
  assign sse = '0;
`endif

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Scoreboard bench for add16u_err_monitor.
// Expected run statistics are queued at start, checked on done.
module tb_add16u_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] n_samples = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [16:0] in_o = '0;

  logic        in_ready, busy, done;
  logic [31:0] smp_cnt, err_cnt;
  logic [16:0] wce;
  logic [47:0] sae;
  logic [63:0] sse;

  logic        s_ready, s_busy, s_done;
  logic [31:0] s_smp, s_errc;
  logic [16:0] s_wce;
  logic [16:0] s_sae;
  logic [63:0] s_sse;

  always #5 clk = ~clk;

  add16u_err_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .n_samples(n_samples), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_o(in_o), .busy(busy), .done(done),
    .smp_cnt(smp_cnt), .err_cnt(err_cnt), .wce(wce),
    .sae(sae), .sse(sse)
  );

  add16u_err_monitor #(.SAE_W(17)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .n_samples(n_samples), .in_valid(in_valid),
    .in_ready(s_ready), .in_a(in_a), .in_b(in_b),
    .in_o(in_o), .busy(s_busy), .done(s_done),
    .smp_cnt(s_smp), .err_cnt(s_errc), .wce(s_wce),
    .sae(s_sae), .sse(s_sse)
  );

  typedef struct {
    string       name;
    logic [63:0] smp;
    logic [63:0] errc;
    logic [63:0] wce;
    logic [63:0] sae;
    logic [63:0] sse;
    logic [63:0] sae17;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   armed = 1'b0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] xsse(logic [63:0] v);
`ifdef ADD16U_ERRMON_MSE_EN
    return v;
`else
    if (v == 64'd0) return 64'd0;
    return 64'd0;
`endif
  endfunction

  task automatic push(string nm, logic [63:0] s,
                      logic [63:0] e, logic [63:0] w,
                      logic [63:0] a, logic [63:0] sq,
                      logic [63:0] a17);
    exp_t x;
    x.name = nm; x.smp = s; x.errc = e; x.wce = w;
    x.sae = a; x.sse = xsse(sq); x.sae17 = a17;
    q.push_back(x);
  endtask

  always @(posedge clk) if (start) armed = 1'b1;

  always @(negedge clk) begin
    if (armed && done) begin
      armed = 1'b0;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got 1 want 0");
      end else begin
        exp_t x;
        x = q.pop_front();
        chk({x.name, "_smp"}, 64'(smp_cnt), x.smp);
        chk({x.name, "_errc"}, 64'(err_cnt), x.errc);
        chk({x.name, "_wce"}, 64'(wce), x.wce);
        chk({x.name, "_sae"}, 64'(sae), x.sae);
        chk({x.name, "_sse"}, sse, x.sse);
        chk({x.name, "_sae17"}, 64'(s_sae), x.sae17);
      end
    end
  end

  task automatic do_start(logic [31:0] n);
    start = 1'b1;
    n_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(logic [15:0] a, logic [15:0] b,
                      logic [16:0] o);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_o = o;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk({nm, "_done_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
  endtask

  logic [15:0] ta[3];
  logic [15:0] tb[3];
  logic [16:0] to[3];

  initial begin
    int acc;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_smp", 64'(smp_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push("t1", 1, 0, 0, 0, 0, 0);
    do_start(1);
    send(16'h0001, 16'h0001, 17'h00002);
    wait_done("t1");

    push("t2", 2, 2, 131071, 131072,
         64'd17179607042, 131071);
    do_start(2);
    send(16'h00FF, 16'h0001, 17'h000FF);
    send(16'h0000, 16'h0000, 17'h1FFFF);
    wait_done("t2");

    push("t6", 2, 2, 131071, 262142,
         64'd34359214082, 131071);
    do_start(2);
    send(16'h0000, 16'h0000, 17'h1FFFF);
    send(16'h0000, 16'h0000, 17'h1FFFF);
    wait_done("t6");

    push("t7", 0, 0, 0, 0, 0, 0);
    do_start(0);
    wait_done("t7");

    ta[0] = 16'h1234; tb[0] = 16'h4321; to[0] = 17'h05555;
    ta[1] = 16'hFFFF; tb[1] = 16'hFFFF; to[1] = 17'h00000;
    ta[2] = 16'h8000; tb[2] = 16'h8000; to[2] = 17'h10005;
    push("t3", 3, 2, 131070, 131075,
         64'd17179344925, 131071);
    do_start(3);
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      if (in_ready) begin
        in_a = ta[acc]; in_b = tb[acc]; in_o = to[acc];
        acc++;
      end
      @(negedge clk);
    end
    chk("t3_accepts", 64'(acc), 64'd3);
    chk("t3_ready_drop", 64'(in_ready), 64'd0);
    begin
      int k = 0;
      while (!done && k < 3) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t3_done_in_3", 64'(done), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);

    do_start(5);
    send(16'h0000, 16'h0000, 17'h00007);
    send(16'h0000, 16'h0000, 17'h00003);
    chk("t4_pipe_smp", 64'(smp_cnt), 64'd1);
    push("t4", 2, 1, 1, 1, 1, 1);
    do_start(2);
    chk("t4_clr_smp", 64'(smp_cnt), 64'd0);
    chk("t4_clr_sae", 64'(sae), 64'd0);
    chk("t4_clr_wce", 64'(wce), 64'd0);
    chk("t4_clr_errc", 64'(err_cnt), 64'd0);
    send(16'h0010, 16'h0010, 17'h00021);
    send(16'h0000, 16'h0001, 17'h00001);
    wait_done("t4");

    do_start(1);
    send(16'h0003, 16'h0004, 17'h00000);
    @(posedge clk);
    #1;
    chk("t5_pre_smp", 64'(smp_cnt), 64'd1);
    chk("t5_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_smp", 64'(smp_cnt), 64'd0);
    chk("t5_rst_sae", 64'(sae), 64'd0);
    chk("t5_rst_wce", 64'(wce), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_ign_ready", 64'(in_ready), 64'd0);
    chk("t5_ign_smp", 64'(smp_cnt), 64'd0);
    chk("t5_ign_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("q_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
